// File: rtl/rx_ld_buf.sv
// Per-lane deskew buffer: captures lane words from the first AM after lock,
// flags half-full for the deskew controller and serves common reads.
module rx_ld_buf #(
    parameter int DW   = 66,
    parameter int AW   = 4,
    parameter int HALF = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr_n,
    input  logic          i_lden,
    input  logic          i_am_locked,
    input  logic          i_vld,
    input  logic [DW-1:0] i_data,
    input  logic          i_is_am,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_data,
    output logic          o_is_am,
    output logic          o_rd_vld,
    output logic          o_wr_half_full_reg,
    output logic          o_flow,
    output logic          o_wr_act,
    output logic [AW:0]   o_level
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_FLOW} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level, level_d, level_q;
    logic [DW:0]   mem_q [DEPTH];
    logic [DW:0]   rd_word;
    logic [DW-1:0] data_q, data_d;
    logic          is_am_q, is_am_d, rd_vld_q, rd_vld_d, hf_q, hf_d;
    logic          clear, full, empty, wr, rd, ovf, unf;

    assign clear   = !i_clr_n || !i_lden || !i_am_locked;
    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        state_d  = state_q;
        wr       = 1'b0;
        rd       = 1'b0;
        ovf      = 1'b0;
        unf      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_vld && i_is_am) begin
                    wr      = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                unf = i_rd_en && empty;
                ovf = i_vld && full && !i_rd_en;
                // The faulting cycle moves neither pointer, so the level
                // shown in FLOW is the level at the moment of the fault.
                if (unf || ovf) begin
                    state_d = ST_FLOW;
                end else begin
                    wr = i_vld;
                    rd = i_rd_en && !empty;
                end
            end
            ST_FLOW: state_d = ST_FLOW;
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
            wr      = 1'b0;
            rd      = 1'b0;
        end

        wr_ptr_d = clear ? '0 : wr_ptr_q + {{AW{1'b0}}, wr};
        rd_ptr_d = clear ? '0 : rd_ptr_q + {{AW{1'b0}}, rd};
        level_d  = wr_ptr_d - rd_ptr_d;

        rd_vld_d = rd;
        is_am_d  = rd && rd_word[DW];
        data_d   = clear ? '0 : (rd ? rd_word[DW-1:0] : data_q);
        hf_d     = !clear && (hf_q || (state_d == ST_WRITE && level_d >= (AW+1)'(HALF)));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            is_am_q  <= 1'b0;
            rd_vld_q <= 1'b0;
            hf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            is_am_q  <= is_am_d;
            rd_vld_q <= rd_vld_d;
            hf_q     <= hf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {i_is_am, i_data};
        end
    end

    assign o_data             = data_q;
    assign o_is_am            = is_am_q;
    assign o_rd_vld           = rd_vld_q;
    assign o_wr_half_full_reg = hf_q;
    assign o_flow             = (state_q == ST_FLOW);
    assign o_wr_act           = (state_q == ST_WRITE);
    assign o_level            = level_q;
endmodule

// File: doc/rx_ld_buf.md
Name: rx_ld_buf

Overview:
- Per-lane deskew buffer; one instance per lane in the RX lane-deskew path. Sits directly upstream of the lane-deskew controller.
- Starts writing on the first alignment-marker (AM) word after lane lock. Raises a half-full flag so the controller can start a common read on all lanes.
- Returns the read word with its AM flag for the controller's match check. Reports overflow/underflow as a sticky flow flag.

Parameters:
- DW, 66, width of one lane word
- AW, 4, address width; depth = 2**AW
- HALF, 8, fill level (words) at which the half-full flag sets; must be < 2**AW

Ports:
- i_clk  in  1  uniform lane clock
- i_rst  in  1  asynchronous reset, active-high
- i_clr_n  in  1  synchronous clear from the deskew controller's reset-all output, active-low
- i_lden  in  1  lane deskew enable
- i_am_locked  in  1  lane AM lock status
- i_vld  in  1  input word valid
- i_data  in  DW  input lane word
- i_is_am  in  1  input word is an alignment marker; qualified by i_vld
- i_rd_en  in  1  common read enable from the controller
- o_data  out  DW  read word, registered
- o_is_am  out  1  read word is AM; 0 when o_rd_vld=0
- o_rd_vld  out  1  o_data/o_is_am valid
- o_wr_half_full_reg  out  1  sticky: fill reached HALF since write start
- o_flow  out  1  sticky overflow/underflow
- o_wr_act  out  1  write FSM in WRITE state
- o_level  out  AW+1  current fill level

Behaviour:

Reset and clear:
- i_rst=1: all outputs 0, pointers 0, FSM = IDLE.
- Synchronous clear (i_clr_n=0, or i_lden=0, or i_am_locked=0) gives the same result on the next edge. Clear has priority over every other action in that cycle.

Storage:
- 2**AW entries, each {is_am, data}.
- wr_ptr and rd_ptr are AW+1 bits and wrap naturally.
- level = wr_ptr - rd_ptr, modulo 2**(AW+1).
- full = (level == 2**AW); empty = (level == 0). Both are evaluated on the pre-edge level.

Write FSM:
- States: IDLE, WRITE, FLOW.
- IDLE → WRITE when i_clr_n & i_lden & i_am_locked & i_vld & i_is_am. That AM word is written in the same cycle; no earlier word is ever written.
- In WRITE, each cycle with i_vld=1 writes {i_is_am, i_data} and increments wr_ptr.
- WRITE → FLOW on either of the following, with o_flow=1 from the next cycle:
  - overflow: write while full and no read in the same cycle;
  - underflow: read while empty (even if a write occurs in the same cycle).
- In FLOW: no writes, no reads, pointers frozen, o_flow stays 1. Exit only through the synchronous clear.

Read path:
- A read occurs when state=WRITE & i_rd_en & !empty. rd_ptr increments.
- 1-cycle latency: o_data/o_is_am/o_rd_vld are registered on the edge of the read.
- o_rd_vld=0 in cycles with no read; o_data then holds its previous value and o_is_am=0.

Simultaneous events:
- Full with write and read in the same cycle: legal, level unchanged.
- Empty with write and read in the same cycle: underflow.

Half-full flag:
- o_wr_half_full_reg sets on the edge where level becomes >= HALF while in WRITE.
- Stays 1 (including in FLOW) until the synchronous clear or i_rst.
- o_level is registered and reflects the post-edge pointers.

Test Plan:
- Lock, lden=1, i_vld=1 every cycle, AM at cycle 5 -> no writes before cycle 5; o_wr_half_full_reg=1 after exactly 8 writes (cycles 5..12); o_level=8.
- Then i_rd_en=1 continuously -> first o_rd_vld with o_is_am=1 and the cycle-5 data, one cycle after the first read; level holds at 8; o_flow stays 0.
- Fill to 16 with no reads, then one more i_vld -> o_flow=1 next cycle; o_level frozen at 16; o_rd_vld=0 even with i_rd_en=1.
- i_clr_n low for 1 cycle while in FLOW -> all flags 0, o_level=0, FSM IDLE; buffer restarts only on the next AM.
- i_rd_en=1 with level=0 and i_vld=1 in the same cycle -> underflow, o_flow=1.
- i_am_locked drops mid-stream at level 5 -> next cycle o_level=0, o_wr_act=0, o_wr_half_full_reg=0.
- i_rst asserted asynchronously mid-read -> outputs 0 immediately.
